// File: rtl/ddr4_ui_responder_if.sv
// DDR4 user-interface bundle between an application master and the memory responder:
// command channel, write-data channel, read-return channel and status flags.
interface ddr4_ui_responder_if;
    logic         calib_done;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [28:0]  app_addr;
    logic         app_rdy;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         cmd_error;

    modport master (
        input  calib_done,
        output app_en,
        output app_cmd,
        output app_addr,
        input  app_rdy,
        output app_wdf_wren,
        output app_wdf_data,
        output app_wdf_end,
        output app_wdf_mask,
        input  app_wdf_rdy,
        input  app_rd_data,
        input  app_rd_data_valid,
        input  app_rd_data_end,
        input  cmd_error
    );

    modport slave (
        output calib_done,
        input  app_en,
        input  app_cmd,
        input  app_addr,
        output app_rdy,
        input  app_wdf_wren,
        input  app_wdf_data,
        input  app_wdf_end,
        input  app_wdf_mask,
        output app_wdf_rdy,
        output app_rd_data,
        output app_rd_data_valid,
        output app_rd_data_end,
        output cmd_error
    );
endinterface

// File: rtl/ddr4_ui_responder.sv
// Behavioural DDR4 UI responder: calibration delay, command and write-data FIFOs,
// in-order executor over a 128-bit word memory, fixed-latency read return.
module ddr4_ui_responder #(
    parameter int MEM_AW       = 8,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int STALL_PERIOD = 0
) (
    input logic                clk,
    input logic                reset_n,
    ddr4_ui_responder_if.slave ui
);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam int DEPTH = 1 << MEM_AW;
    localparam int THR_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [THR_W-1:0] THR_LAST = (STALL_PERIOD > 0) ? THR_W'(STALL_PERIOD - 1) : '0;

    // Calibration timer: down-counter, calib_done latches on terminal count.
    logic [15:0] cal_cnt;
    logic        calib_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cal_cnt    <= 16'(CALIB_CYCLES);
            calib_done <= 1'b0;
        end else if (cal_cnt != 16'd0) begin
            cal_cnt <= cal_cnt - 16'd1;
            if (cal_cnt == 16'd1) begin
                calib_done <= 1'b1;
            end
        end
    end

    logic [THR_W-1:0] thr_cnt;
    logic             throttle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_cnt <= '0;
        end else if (STALL_PERIOD > 0) begin
            thr_cnt <= (thr_cnt == THR_LAST) ? '0 : thr_cnt + THR_W'(1);
        end
    end

    assign throttle = (STALL_PERIOD > 0) && (thr_cnt == THR_LAST);

    // Command queue holds the already-truncated word index; the error check happens at acceptance.
    logic [2:0]        cq_cmd [4];
    logic [MEM_AW-1:0] cq_idx [4];
    logic [1:0]        cq_wp;
    logic [1:0]        cq_rp;
    logic [2:0]        cq_cnt;
    logic              cq_full;
    logic              cq_empty;
    logic              cq_push;
    logic              cq_pop;
    logic              app_rdy;

    assign cq_full  = (cq_cnt == 3'd4);
    assign cq_empty = (cq_cnt == 3'd0);
    assign app_rdy  = calib_done && !cq_full && !throttle;
    assign cq_push  = ui.app_en && app_rdy;

    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_cmd[cq_wp] <= ui.app_cmd;
            cq_idx[cq_wp] <= ui.app_addr[MEM_AW+2:3];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cq_wp  <= 2'd0;
            cq_rp  <= 2'd0;
            cq_cnt <= 3'd0;
        end else begin
            if (cq_push) cq_wp <= cq_wp + 2'd1;
            if (cq_pop)  cq_rp <= cq_rp + 2'd1;
            cq_cnt <= cq_cnt + 3'(cq_push) - 3'(cq_pop);
        end
    end

    logic [127:0] wdf_data [4];
    logic [15:0]  wdf_mask [4];
    logic [1:0]   wdf_wp;
    logic [1:0]   wdf_rp;
    logic [2:0]   wdf_cnt;
    logic         wdf_full;
    logic         wdf_empty;
    logic         wdf_rdy;
    logic         wdf_push;
    logic         wdf_pop;

    assign wdf_full  = (wdf_cnt == 3'd4);
    assign wdf_empty = (wdf_cnt == 3'd0);
    assign wdf_rdy   = calib_done && !wdf_full;
    assign wdf_push  = ui.app_wdf_wren && wdf_rdy;

    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data[wdf_wp] <= ui.app_wdf_data;
            wdf_mask[wdf_wp] <= ui.app_wdf_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdf_wp  <= 2'd0;
            wdf_rp  <= 2'd0;
            wdf_cnt <= 3'd0;
        end else begin
            if (wdf_push) wdf_wp <= wdf_wp + 2'd1;
            if (wdf_pop)  wdf_rp <= wdf_rp + 2'd1;
            wdf_cnt <= wdf_cnt + 3'(wdf_push) - 3'(wdf_pop);
        end
    end

    // Executor: a write head waits for data; reads and unknown commands always retire.
    logic [2:0]        head_cmd;
    logic [MEM_AW-1:0] head_idx;
    logic              exec_wr;
    logic              exec_rd;

    assign head_cmd = cq_cmd[cq_rp];
    assign head_idx = cq_idx[cq_rp];
    assign exec_wr  = !cq_empty && (head_cmd == CMD_WR) && !wdf_empty;
    assign exec_rd  = !cq_empty && (head_cmd == CMD_RD);
    assign cq_pop   = !cq_empty && ((head_cmd != CMD_WR) || !wdf_empty);
    assign wdf_pop  = exec_wr;

    logic [127:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < 16; b++) begin
                if (!wdf_mask[wdf_rp][b]) begin
                    mem[head_idx][8*b +: 8] <= wdf_data[wdf_rp][8*b +: 8];
                end
            end
        end
    end

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [127:0]          pipe_data [RD_LATENCY];
    logic                  rd_valid;
    logic [127:0]          rd_data;

    always_ff @(posedge clk) begin
        pipe_data[0] <= mem[head_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            pipe_vld[0] <= exec_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            rd_valid <= pipe_vld[RD_LATENCY-1];
            if (pipe_vld[RD_LATENCY-1]) begin
                rd_data <= pipe_data[RD_LATENCY-1];
            end
        end
    end

    logic cmd_bad;
    logic addr_bad;
    logic cmd_error;

    assign cmd_bad  = (ui.app_cmd != CMD_WR) && (ui.app_cmd != CMD_RD);
    assign addr_bad = (ui.app_addr[2:0] != 3'd0) || ((ui.app_addr >> (MEM_AW + 3)) != 29'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_error <= 1'b0;
        end else if ((cq_push && (cmd_bad || addr_bad)) || (wdf_push && !ui.app_wdf_end)) begin
            cmd_error <= 1'b1;
        end
    end

    assign ui.calib_done        = calib_done;
    assign ui.app_rdy           = app_rdy;
    assign ui.app_wdf_rdy       = wdf_rdy;
    assign ui.app_rd_data       = rd_data;
    assign ui.app_rd_data_valid = rd_valid;
    assign ui.app_rd_data_end   = rd_valid;
    assign ui.cmd_error         = cmd_error;
endmodule
